// File: rtl/keypad_pkg.sv
// Shared types and helpers for the matrix keypad scanner.
// Holds the emit-engine state encoding, the debug struct and the legacy digit map.
package keypad_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } kp_emit_state_t;

  typedef struct packed {
    kp_emit_state_t emit_state;
    logic           fifo_full;
  } kp_dbg_t;

  localparam int unsigned STABLE_W = 4;

  // Legacy 4x4 keycap layout: r0 1 2 3 A, r1 4 5 6 B, r2 7 8 9 C, r3 0 F E D.
  function automatic logic [3:0] hex_of_index(input logic [3:0] idx);
    logic [3:0] h;
    h = 4'h0;
    case (idx)
      4'd0:  h = 4'h1;
      4'd1:  h = 4'h2;
      4'd2:  h = 4'h3;
      4'd3:  h = 4'hA;
      4'd4:  h = 4'h4;
      4'd5:  h = 4'h5;
      4'd6:  h = 4'h6;
      4'd7:  h = 4'hB;
      4'd8:  h = 4'h7;
      4'd9:  h = 4'h8;
      4'd10: h = 4'h9;
      4'd11: h = 4'hC;
      4'd12: h = 4'h0;
      4'd13: h = 4'hF;
      4'd14: h = 4'hE;
      4'd15: h = 4'hD;
      default: h = 4'h0;
    endcase
    return h;
  endfunction

endpackage

// File: rtl/kp_event_fifo.sv
// Synchronous event FIFO with a sticky drop flag.
// A push into a full FIFO is accepted only when a pop frees the head in the same cycle.
module kp_event_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_drop
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_chk_depth
    $error("kp_event_fifo: DEPTH must be a power of 2 and at least 2");
  end

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             r_drop;
  logic             w_do_pop;
  logic             w_do_push;

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = r_mem[r_rd_ptr[AW-1:0]];
  assign o_drop    = r_drop;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_drop   <= 1'b0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (i_push && !w_do_push) r_drop <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: column drive, frame debounce, per-key press/release events.
// Events leave through a FIFO: ev_valid = head present; a beat transfers on ev_valid && ev_ready, and ev_code/ev_press hold while stalled.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter  int NUM_ROWS        = 4,
  parameter  int NUM_COLS        = 4,
  parameter  int COL_CYCLES      = 100000,
  parameter  int SETTLE_CYCLES   = 8,
  parameter  int DEBOUNCE_FRAMES = 4,
  parameter  int FIFO_DEPTH      = 4,
  localparam int IDX_W           = $clog2(NUM_ROWS * NUM_COLS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_ROWS-1:0] row_n,
  output logic [NUM_COLS-1:0] col_n,
  output logic                ev_valid,
  input  logic                ev_ready,
  output logic [IDX_W-1:0]    ev_code,
  output logic                ev_press,
  output logic                key_down,
  output logic [IDX_W-1:0]    held_code,
  output logic                overflow,
  output kp_dbg_t             dbg
);

  localparam int N     = NUM_ROWS * NUM_COLS;
  localparam int COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam int DW    = $clog2(COL_CYCLES);

  if (COL_CYCLES <= SETTLE_CYCLES + 1) begin : g_chk_settle
    $error("keypad_scanner: COL_CYCLES must exceed SETTLE_CYCLES+1");
  end
  if (NUM_COLS * COL_CYCLES < N + 2) begin : g_chk_frame
    $error("keypad_scanner: frame too short for the emit walk");
  end
  if (DEBOUNCE_FRAMES < 1 || DEBOUNCE_FRAMES > 15) begin : g_chk_deb
    $error("keypad_scanner: DEBOUNCE_FRAMES must be 1..15");
  end

  logic                r_run;
  logic [COL_W-1:0]    r_col_idx;
  logic [DW-1:0]       r_dwell;
  logic [N-1:0]        r_raw;
  logic [N-1:0]        r_prev;
  logic [N-1:0]        r_committed;
  logic [N-1:0]        r_diff;
  logic [STABLE_W-1:0] r_stable_cnt;
  logic [STABLE_W-1:0] w_stable_next;
  logic                w_sample;
  logic                w_frame_end;
  logic                w_commit;
  kp_emit_state_t      r_state;
  kp_emit_state_t      w_state_next;
  logic [IDX_W-1:0]    r_emit_idx;
  logic                w_last_idx;
  logic                w_push;
  logic [IDX_W:0]      w_fifo_din;
  logic [IDX_W:0]      w_fifo_dout;
  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic [IDX_W-1:0]    w_held;

  // r_run gates the scan so the first post-reset cycle is frame cycle 0.
  assign col_n       = r_run ? ~(NUM_COLS'(1) << r_col_idx) : '1;
  assign w_sample    = r_run && (r_dwell == DW'(SETTLE_CYCLES));
  assign w_frame_end = r_run && (r_dwell == DW'(SETTLE_CYCLES + 1)) &&
                       (r_col_idx == COL_W'(NUM_COLS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_run     <= 1'b0;
      r_col_idx <= '0;
      r_dwell   <= '0;
      r_raw     <= '0;
    end else begin
      r_run <= 1'b1;
      if (r_run) begin
        if (r_dwell == DW'(COL_CYCLES - 1)) begin
          r_dwell   <= '0;
          r_col_idx <= (r_col_idx == COL_W'(NUM_COLS - 1)) ? '0 : r_col_idx + 1'b1;
        end else begin
          r_dwell <= r_dwell + 1'b1;
        end
        if (w_sample) begin
          for (int r = 0; r < NUM_ROWS; r++) begin
            for (int c = 0; c < NUM_COLS; c++) begin
              if (r_col_idx == COL_W'(c)) r_raw[r*NUM_COLS+c] <= ~row_n[r];
            end
          end
        end
      end
    end
  end

  assign w_stable_next = (r_raw != r_prev) ? STABLE_W'(1) :
                         (r_stable_cnt >= STABLE_W'(DEBOUNCE_FRAMES)) ? STABLE_W'(DEBOUNCE_FRAMES) :
                         r_stable_cnt + 1'b1;
  assign w_commit = w_frame_end && (w_stable_next == STABLE_W'(DEBOUNCE_FRAMES)) &&
                    (r_raw != r_committed);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev       <= '0;
      r_committed  <= '0;
      r_diff       <= '0;
      r_stable_cnt <= '0;
    end else if (w_frame_end) begin
      r_prev       <= r_raw;
      r_stable_cnt <= w_stable_next;
      if (w_commit) begin
        r_diff      <= r_raw ^ r_committed;
        r_committed <= r_raw;
      end
    end
  end

  assign w_last_idx = (r_emit_idx == IDX_W'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_emit_idx <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == EMIT) r_emit_idx <= w_last_idx ? '0 : r_emit_idx + 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_commit) w_state_next = EMIT;
      EMIT:    if (w_last_idx) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // r_committed cannot change during the walk, so it supplies the event polarity.
  always_comb begin
    w_push     = 1'b0;
    w_fifo_din = {r_emit_idx, r_committed[r_emit_idx]};
    if (r_state == EMIT) w_push = r_diff[r_emit_idx];
  end

  kp_event_fifo #(
    .WIDTH(IDX_W + 1),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_push (w_push),
    .i_data (w_fifo_din),
    .i_pop  (ev_valid && ev_ready),
    .o_data (w_fifo_dout),
    .o_full (w_fifo_full),
    .o_empty(w_fifo_empty),
    .o_drop (overflow)
  );

  assign ev_valid            = !w_fifo_empty;
  assign {ev_code, ev_press} = w_fifo_dout;

  always_comb begin
    w_held = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (r_committed[i]) w_held = IDX_W'(i);
    end
  end

  assign key_down       = |r_committed;
  assign held_code      = w_held;
  assign dbg.emit_state = r_state;
  assign dbg.fifo_full  = w_fifo_full;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a 4x4 key matrix model feeds row_n from col_n,
// and hand-computed expectations are checked at the falling clock edge.
module tb_keypad_scanner;
  import keypad_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic        ev_valid;
  logic        ev_ready;
  logic [3:0]  ev_code;
  logic        ev_press;
  logic        key_down;
  logic [3:0]  held_code;
  logic        overflow;
  kp_dbg_t     dbg;
  logic [15:0] keys;

  int n_cmp = 0;
  int n_err = 0;

  localparam int FRAME = 64;

  always #5 clk = ~clk;

  keypad_scanner #(
    .NUM_ROWS(4), .NUM_COLS(4), .COL_CYCLES(16), .SETTLE_CYCLES(2),
    .DEBOUNCE_FRAMES(3), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .row_n(row_n), .col_n(col_n),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code), .ev_press(ev_press),
    .key_down(key_down), .held_code(held_code), .overflow(overflow), .dbg(dbg)
  );

  // Switch matrix: a closed key pulls its row low while its column is driven.
  always_comb begin
    row_n = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic frames(input int n);
    repeat (n * FRAME) @(negedge clk);
  endtask

  task automatic wait_event(input string tag, input logic [3:0] exp_code, input logic exp_press);
    int t;
    t = 0;
    while (!ev_valid && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check({tag, " valid"}, 32'(ev_valid), 32'd1);
    if (ev_valid) begin
      check({tag, " code"}, 32'(ev_code), 32'(exp_code));
      check({tag, " press"}, 32'(ev_press), 32'(exp_press));
      ev_ready = 1'b1;
      @(negedge clk);
      ev_ready = 1'b0;
    end
  endtask

  task automatic wait_key_down(input string tag);
    int t;
    t = 0;
    while (!key_down && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check(tag, 32'(key_down), 32'd1);
  endtask

  initial begin
    int t;
    rst      = 1'b1;
    ev_ready = 1'b0;
    keys     = '0;

    check("hex 14", 32'(hex_of_index(4'd14)), 32'hE);
    check("hex 7", 32'(hex_of_index(4'd7)), 32'hB);
    check("hex 12", 32'(hex_of_index(4'd12)), 32'h0);

    // Reset values and column sequencing
    repeat (5) @(negedge clk);
    check("rst col_n", 32'(col_n), 32'hF);
    check("rst ev_valid", 32'(ev_valid), 32'd0);
    check("rst overflow", 32'(overflow), 32'd0);
    check("rst key_down", 32'(key_down), 32'd0);
    check("rst held_code", 32'(held_code), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("col0 drive", 32'(col_n), 32'hE);
    repeat (16) @(negedge clk);
    check("col1 drive", 32'(col_n), 32'hD);

    // Single key 6 (row 1, column 2)
    keys[6] = 1'b1;
    frames(5);
    check("single queued", 32'(ev_valid), 32'd1);
    check("single key_down", 32'(key_down), 32'd1);
    check("single held", 32'(held_code), 32'd6);
    wait_event("single press", 4'd6, 1'b1);
    check("single one event", 32'(ev_valid), 32'd0);
    keys[6] = 1'b0;
    frames(5);
    check("release key_down", 32'(key_down), 32'd0);
    check("release held", 32'(held_code), 32'd0);
    wait_event("single release", 4'd6, 1'b0);
    check("release one event", 32'(ev_valid), 32'd0);

    // Bounce: toggling once per frame never commits
    for (int i = 0; i < 10; i++) begin
      keys[6] = ~keys[6];
      frames(1);
      check("bounce key_down", 32'(key_down), 32'd0);
    end
    frames(5);
    check("bounce no event", 32'(ev_valid), 32'd0);

    // Simultaneous keys 1 and 14: pushes land 2 and 15 cycles after commit
    keys = 16'h4002;
    wait_key_down("sim commit");
    t = 0;
    while (!ev_valid && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("sim first delay", 32'(t), 32'd2);
    check("sim first code", 32'(ev_code), 32'd1);
    check("sim first press", 32'(ev_press), 32'd1);
    ev_ready = 1'b1;
    @(negedge clk);
    ev_ready = 1'b0;
    t++;
    check("sim pop empties", 32'(ev_valid), 32'd0);
    while (!ev_valid && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("sim second delay", 32'(t), 32'd15);
    check("sim second code", 32'(ev_code), 32'd14);
    check("sim second press", 32'(ev_press), 32'd1);
    check("sim held", 32'(held_code), 32'd1);
    ev_ready = 1'b1;
    @(negedge clk);
    ev_ready = 1'b0;
    keys = '0;
    wait_event("sim rel 1", 4'd1, 1'b0);
    wait_event("sim rel 14", 4'd14, 1'b0);
    check("sim rel key_down", 32'(key_down), 32'd0);

    // Overflow: six events into four slots with the consumer stalled
    for (int i = 0; i < 3; i++) begin
      keys[0] = 1'b1;
      frames(5);
      keys[0] = 1'b0;
      frames(5);
    end
    check("ovf flag", 32'(overflow), 32'd1);
    check("ovf full", 32'(dbg.fifo_full), 32'd1);
    check("ovf head code", 32'(ev_code), 32'd0);
    check("ovf head press", 32'(ev_press), 32'd1);
    wait_event("ovf ev0", 4'd0, 1'b1);
    wait_event("ovf ev1", 4'd0, 1'b0);
    wait_event("ovf ev2", 4'd0, 1'b1);
    wait_event("ovf ev3", 4'd0, 1'b0);
    check("ovf drained", 32'(ev_valid), 32'd0);
    check("ovf sticky", 32'(overflow), 32'd1);

    // Reset in the middle of a three-key emit walk
    keys = 16'h8021;
    wait_key_down("mid commit");
    repeat (3) @(negedge clk);
    check("mid emitting", 32'(dbg.emit_state), 32'(EMIT));
    check("mid first queued", 32'(ev_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid rst ev_valid", 32'(ev_valid), 32'd0);
    check("mid rst overflow", 32'(overflow), 32'd0);
    check("mid rst key_down", 32'(key_down), 32'd0);
    check("mid rst col_n", 32'(col_n), 32'hF);
    check("mid rst state", 32'(dbg.emit_state), 32'(IDLE));
    rst = 1'b0;
    wait_event("mid re 0", 4'd0, 1'b1);
    wait_event("mid re 5", 4'd5, 1'b1);
    wait_event("mid re 15", 4'd15, 1'b1);
    check("mid re held", 32'(held_code), 32'd0);
    check("mid re empty", 32'(ev_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
